// File: rtl/scan_seq16.sv
// scan_seq16 -- line-scan sequencer feeding the a0..a3 selects of a 4-to-16 decoder.
// Steps a 4-bit line index up (0->15) or down (15->0) and holds each line for DIV clocks.
// It runs in continuous or single-pass mode, has start/stop control, and pulses done.
// Optional feature: define SCAN_SKIP_EN to add the skip_mask input. Lines whose mask bit
// is set are skipped, and the mask is sampled live.
module scan_seq16 #(
  parameter int DIV   = 4,
  parameter int DIV_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        dir,
  input  logic        single,
`ifdef SCAN_SKIP_EN
  input  logic [15:0] skip_mask,
`endif
  output logic        a0,
  output logic        a1,
  output logic        a2,
  output logic        a3,
  output logic [3:0]  idx,
  output logic        line_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  state_t           state_r;
  logic [DIV_W-1:0] cnt_r;
  logic             dir_r;
  logic             single_r;
  logic [15:0]      mask_s;
  logic [4:0]       first_s;   // {found, index}
  logic [4:0]       next_s;    // {found, index}

`ifdef SCAN_SKIP_EN
  assign mask_s = skip_mask;
`else
  assign mask_s = 16'h0000;
`endif

  // Find the first unmasked line counted from the start end of the scan direction.
  // The loop runs from the far end, so the nearest candidate is written last and wins.
  function automatic logic [4:0] find_first(input logic down, input logic [15:0] mask);
    logic [4:0] res;
    logic [3:0] cand;
    res = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      cand = down ? 4'(15 - k) : 4'(k);
      if (!mask[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Find the next unmasked line after cur in the scan direction.
  // Without wrap, only lines strictly ahead of cur are eligible, so "not found" marks the
  // terminal line. With wrap, the search goes past the end and may land back on cur itself.
  function automatic logic [4:0] find_next(input logic [3:0]  cur,
                                           input logic        down,
                                           input logic [15:0] mask,
                                           input logic        wrap);
    logic [4:0] res;
    logic [4:0] step;
    logic [3:0] cand;
    logic       ahead;
    res = 5'd0;
    for (int k = 16; k >= 1; k--) begin
      step  = 5'(k);
      cand  = down ? (cur - step[3:0]) : (cur + step[3:0]);
      ahead = down ? (step <= {1'b0, cur}) : (step <= (5'd15 - {1'b0, cur}));
      if (!mask[cand] && (wrap || ahead)) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Candidate indices: the first line for a new scan, and the following line for a tick.
  always_comb begin
    first_s = find_first(dir, mask_s);
    next_s  = find_next(idx, dir_r, mask_s, !single_r);
  end

  // Decoder selects come straight from the registered index; a0 is the MSB.
  assign a0 = idx[3];
  assign a1 = idx[2];
  assign a2 = idx[1];
  assign a3 = idx[0];

  // Sequencer FSM: prescaler, index stepping, mode latching and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx      <= 4'd0;
      dir_r    <= 1'b0;
      single_r <= 1'b0;
      line_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start && !stop && first_s[4]) begin
            state_r  <= RUN;
            idx      <= first_s[3:0];
            cnt_r    <= '0;
            dir_r    <= dir;
            single_r <= single;
            line_en  <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (stop) begin
            // Abort: idx and count hold, and no done pulse is given.
            state_r <= IDLE;
            line_en <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
            if (!next_s[4] && single_r) begin
              // Terminal tick of a single pass: idx keeps the terminal line.
              state_r <= IDLE;
              line_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (next_s[4]) begin
              idx <= next_s[3:0];
            end else begin
              // Every line is masked mid-scan: stay on the current line.
              idx <= idx;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          line_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq16.sv
// Scoreboard bench for scan_seq16: three instances (DIV = 4, 1, 2) share one stimulus stream.
// The driver updates a time-based reference model each cycle and queues the expected outputs.
// The line index is derived as (elapsed clocks / DIV) into the ordered list of unmasked lines.
// A monitor pops the queue 1 ns after every clock edge and compares the model with all instances.
module tb_scan_seq16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir = 1'b0;
  logic        single = 1'b0;
  logic [15:0] mask = 16'h0000;
  logic [15:0] next_mask = 16'h0000;

  logic [3:0] idx_a [3];
  logic [2:0] a0_a, a1_a, a2_a, a3_a, len_a, busy_a, done_a;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  logic [32:0] exp_q [$];

  bit         m_run    [3];
  bit         m_done   [3];
  bit         m_dir    [3];
  bit         m_single [3];
  int         m_t      [3];
  logic [3:0] m_idx    [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DV = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    scan_seq16 #(.DIV(DV), .DIV_W(8)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .dir     (dir),
      .single  (single),
`ifdef SCAN_SKIP_EN
      .skip_mask(mask),
`endif
      .a0      (a0_a[g]),
      .a1      (a1_a[g]),
      .a2      (a2_a[g]),
      .a3      (a3_a[g]),
      .idx     (idx_a[g]),
      .line_en (len_a[g]),
      .busy    (busy_a[g]),
      .done    (done_a[g])
    );
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction

  function automatic int count_unmasked(input logic [15:0] mk);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) if (!mk[k]) n++;
    return n;
  endfunction

  // The n-th unmasked line in scan order (up: 0..15, down: 15..0).
  function automatic logic [3:0] nth_unmasked(input bit down, input logic [15:0] mk, input int n);
    int seen;
    int line;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      line = down ? 15 - k : k;
      if (!mk[line]) begin
        if (seen == n) return 4'(line);
        seen++;
      end
    end
    return 4'd0;
  endfunction

  // One clock of stimulus; the model state describes the outputs after the next edge.
  task automatic cyc(input bit r, input bit s, input bit p, input bit d, input bit sg);
    logic [32:0] e;
    int n;
    int dv;
    @(posedge clk);
    #2;
    rst = r; start = s; stop = p; dir = d; single = sg; mask = next_mask;
    n = count_unmasked(mask);
    e = '0;
    for (int i = 0; i < 3; i++) begin
      dv = div_of(i);
      if (r) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_idx[i] = 4'd0;
        m_dir[i] = 1'b0; m_single[i] = 1'b0; m_t[i] = 0;
      end else if (!m_run[i]) begin
        m_done[i] = 1'b0;
        if (s && !p && n > 0) begin
          m_run[i] = 1'b1; m_t[i] = 0; m_dir[i] = d; m_single[i] = sg;
          m_idx[i] = nth_unmasked(d, mask, 0);
        end
      end else begin
        m_done[i] = 1'b0;
        if (p) begin
          m_run[i] = 1'b0;
        end else begin
          m_t[i]++;
          if (m_single[i] && m_t[i] == n * dv) begin
            m_run[i] = 1'b0; m_done[i] = 1'b1;
          end else begin
            m_idx[i] = nth_unmasked(m_dir[i], mask, (m_t[i] / dv) % n);
          end
        end
      end
      e[i*11 +: 11] = {m_idx[i], m_idx[i], m_run[i], m_run[i], m_done[i]};
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every instance against the queued expectation just after each edge.
  initial begin
    logic [32:0] e;
    logic [10:0] act;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          act = {idx_a[i], a0_a[i], a1_a[i], a2_a[i], a3_a[i], len_a[i], busy_a[i], done_a[i]};
          n_checks++;
          if (act === e[i*11 +: 11]) begin
            n_pass++;
          end else begin
            $display("FAIL outputs div=%0d cycle=%0d got {idx,a,en,busy,done}=%b expected %b",
                     div_of(i), cyc_no, act, e[i*11 +: 11]);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    // Single pass up: the DIV=4 instance signals done 64 clocks after the first line.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(70);
    // Continuous down, then stop.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(40);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Continuous up, then stop together with start while DIV=4 sits mid-dwell on line 7.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(29);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // start and stop together while idle: stop wins.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Single pass up with stop on the terminal tick of DIV=4: no done pulse.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(63);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Reset while DIV=4 is on line 9.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(37);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
`ifdef SCAN_SKIP_EN
    next_mask = 16'hFF0F;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(20);
    next_mask = 16'hFFFF;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    next_mask = 16'h0000;
    idle(1);
`endif
    for (int k = 0; k < 3000; k++) begin
`ifdef SCAN_SKIP_EN
      if (!m_run[0] && !m_run[1] && !m_run[2] && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       next_mask = 16'h0000;
          1:       next_mask = 16'hFFFF;
          default: next_mask = 16'($urandom);
        endcase
      end
`endif
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom));
    end
    idle(2);
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
